reset_sequencer: RTL

Parametrised reset controller that sits downstream of the board-level reset synchroniser. It merges power-on reset, a software reset request and NUM_REQ asynchronous reset requests (watchdog, debugger, PLL-unlock). It generates NUM_OUT reset outputs for subsystems. All outputs assert together; they deassert in index order with a programmable gap after a minimum hold time. A sticky cause register records which source(s) triggered the last reset.

---
 rtl/reset_sequencer.sv | 110 +++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Reset controller: merges POR, software and synchronised async requests, asserts all
// subsystem resets together and releases them in index order after a hold time.
module reset_sequencer #(
    parameter int NUM_OUT     = 3,
    parameter int NUM_REQ     = 2,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_async,
    input  logic               sw_req,
    output logic [NUM_OUT-1:0] rst_out,
    output logic               ready,
    output logic [NUM_REQ+1:0] cause
);
    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(NUM_OUT + 1);

    typedef enum logic [1:0] {S_ASSERT, S_HOLD, S_RELEASE, S_RUN} state_t;

    state_t                                state_q;
    logic [CW-1:0]                         cnt_q;
    logic [IW-1:0]                         idx_q;
    logic [NUM_OUT-1:0]                    rst_out_q;
    logic                                  ready_q;
    logic [NUM_REQ+1:0]                    cause_q;
    logic [NUM_REQ-1:0][SYNC_STAGES-1:0]   sync_q;
    logic [NUM_REQ-1:0]                    req_sync;
    logic                                  any_req;
    logic [NUM_REQ+1:0]                    new_cause;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], req_async[i]};
        end
    end

    always_comb begin
        req_sync = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req_sync[i] = sync_q[i][SYNC_STAGES-1];
    end

    assign any_req   = (|req_sync) | sw_req;
    assign new_cause = {req_sync, sw_req, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            cause_q   <= {{(NUM_REQ+1){1'b0}}, 1'b1};
        end else if (any_req) begin
            state_q   <= S_ASSERT;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            cause_q   <= (state_q == S_ASSERT) ? (cause_q | new_cause) : new_cause;
        end else begin
            case (state_q)
                S_ASSERT: begin
                    state_q <= S_HOLD;
                    cnt_q   <= '0;
                end
                S_HOLD: begin
                    if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                        state_q      <= S_RELEASE;
                        rst_out_q[0] <= 1'b0;
                        idx_q        <= IW'(1);
                        cnt_q        <= '0;
                    end else if (cnt_q != CW'(MAXC)) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RELEASE: begin
                    // idx_q is the next bit to release; reaching NUM_OUT means the final gap before ready
                    if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                        cnt_q <= '0;
                        if (idx_q == IW'(NUM_OUT)) begin
                            state_q <= S_RUN;
                            ready_q <= 1'b1;
                        end else begin
                            rst_out_q <= rst_out_q & ~(NUM_OUT'(1) << idx_q);
                            idx_q     <= idx_q + IW'(1);
                        end
                    end else if (cnt_q != CW'(MAXC)) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= S_RUN;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign rst_out = rst_out_q;
    assign ready   = ready_q;
    assign cause   = cause_q;
endmodule
